// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One spare bit so the counter never wraps when STEPS is a power of two.
  function automatic int cnt_w(input int steps);
    return $clog2(steps) + 1;
  endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational ripple of BITS_PER_CYCLE full adders.
module fa_slice #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] a_s,
  input  logic [BITS_PER_CYCLE-1:0] b_s,
  input  logic                      c_in,
  output logic [BITS_PER_CYCLE-1:0] s,
  output logic                      c_out
);

  logic [BITS_PER_CYCLE:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fa
    assign s[i]   = a_s[i] ^ b_s[i] ^ c[i];
    assign c[i+1] = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
  end

  assign c_out = c[BITS_PER_CYCLE];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: BITS_PER_CYCLE bits per clock, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port for two's-complement subtraction.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = cnt_w(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
  end

  state_t                    state, state_nxt;
  logic [WIDTH-1:0]          a_sh, b_sh, sum_r, sum_nxt, b_load;
  logic                      carry, cout_r, c_load;
  logic [CW-1:0]             step;
  logic [BITS_PER_CYCLE-1:0] sl_s;
  logic                      sl_c;
  logic                      accept;

  // Subtraction folds into the adder: invert B and force carry-in.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign accept = in_valid && (state == IDLE);

  fa_slice #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_slice (
    .a_s   (a_sh[BITS_PER_CYCLE-1:0]),
    .b_s   (b_sh[BITS_PER_CYCLE-1:0]),
    .c_in  (carry),
    .s     (sl_s),
    .c_out (sl_c)
  );

  // Slice results enter at the MSB end so the word is aligned after STEPS shifts.
  if (BITS_PER_CYCLE == WIDTH) begin : g_sum_full
    assign sum_nxt = sl_s;
  end else begin : g_sum_shift
    assign sum_nxt = {sl_s, sum_r[WIDTH-1:BITS_PER_CYCLE]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (step == LAST) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      step   <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_load;
      carry <= c_load;
      step  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> BITS_PER_CYCLE;
      b_sh   <= b_sh >> BITS_PER_CYCLE;
      sum_r  <= sum_nxt;
      carry  <= sl_c;
      cout_r <= sl_c;
      step   <= step + CW'(1);
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: two instances (1 and 4 bits per cycle), directed cases plus random traffic.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv[2], ir[2], ov[2], ordy[2], cin[2], sub[2], cout[2];
  logic [7:0] a[2], b[2], sum[2];
  int         nvec = 0;
  int         nerr = 0;
  int         steps[2] = '{8, 2};

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum[0]), .cout(cout[0])
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum[1]), .cout(cout[1])
  );

  // Reference: plain 9-bit arithmetic, {cout, sum}.
  function automatic logic [8:0] model(input logic [7:0] x, y, input logic c, s);
`ifdef SERIAL_ADDER_SUB_EN
    if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
`endif
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  function automatic logic rnd_sub();
`ifdef SERIAL_ADDER_SUB_EN
    return 1'($urandom);
`else
    return 1'b0;
`endif
  endfunction

  // Present one operand set, wait for acceptance, then count cycles until out_valid.
  task automatic issue(input int d, input logic [7:0] x, y, input logic c, s, output int lat);
    int k = 0;
    @(negedge clk);
    iv[d] = 1'b1; a[d] = x; b[d] = y; cin[d] = c; sub[d] = s;
    while (!ir[d] && k < 50) begin @(negedge clk); k++; end
    if (!ir[d]) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout dut%0d: in_ready=%b, required 1", d, ir[d]);
    end
    @(negedge clk);
    iv[d] = 1'b0; a[d] = 8'($urandom); b[d] = 8'($urandom); cin[d] = 1'($urandom); sub[d] = rnd_sub();
    lat = 0;
    while (!ov[d] && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic pop(input int d);
    @(negedge clk); ordy[d] = 1'b1;
    @(negedge clk); ordy[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; a[d] = '0; b[d] = '0; cin[d] = 1'b0; sub[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({ir[d], ov[d], cout[d], sum[d]} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
        nerr++;
        $display("FAIL reset dut%0d: ir=%b ov=%b cout=%b sum=%h, required 1 0 0 00", d, ir[d], ov[d], cout[d], sum[d]);
      end
    end
  endtask

  task automatic test_add_vectors();
    logic [7:0] ta[3]  = '{8'h0F, 8'hFF, 8'h00};
    logic [7:0] tb_[3] = '{8'h01, 8'h01, 8'h00};
    logic       tc[3]  = '{1'b0, 1'b0, 1'b1};
    logic [8:0] te[3]  = '{9'h010, 9'h100, 9'h001};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(0, ta[i], tb_[i], tc[i], 1'b0, lat);
      nvec++;
      if (lat !== 8) begin nerr++; $display("FAIL add%0d_latency: %0d, required 8", i, lat); end
      nvec++;
      if ({cout[0], sum[0]} !== te[i]) begin
        nerr++; $display("FAIL add%0d_result: cout,sum=%h, required %h", i, {cout[0], sum[0]}, te[i]);
      end
      pop(0);
      nvec++;
      if ({ov[0], ir[0]} !== 2'b01) begin
        nerr++; $display("FAIL add%0d_release: ov,ir=%b, required 01", i, {ov[0], ir[0]});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] x = 8'($urandom), y = 8'($urandom);
    logic       c = 1'($urandom);
    logic [8:0] e = model(x, y, c, 1'b0);
    int lat;
    issue(0, x, y, c, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if ({ov[0], ir[0], cout[0], sum[0]} !== {2'b10, e}) begin
        nerr++;
        $display("FAIL backpressure_hold cyc%0d: ov=%b ir=%b cout,sum=%h, required 1 0 %h", i, ov[0], ir[0], {cout[0], sum[0]}, e);
      end
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    nvec++;
    if ({ov[0], ir[0]} !== 2'b01) begin
      nerr++; $display("FAIL backpressure_release: ov,ir=%b, required 01", {ov[0], ir[0]});
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen = 1'b0;
    int lat;
    @(negedge clk);
    iv[0] = 1'b1; a[0] = 8'hAA; b[0] = 8'h55; cin[0] = 1'b0; sub[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if ({ir[0], ov[0], cout[0], sum[0]} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      nerr++;
      $display("FAIL midrun_reset: ir=%b ov=%b cout=%b sum=%h, required 1 0 0 00", ir[0], ov[0], cout[0], sum[0]);
    end
    ordy[0] = 1'b1;
    repeat (12) begin @(negedge clk); if (ov[0]) seen = 1'b1; end
    ordy[0] = 1'b0;
    nvec++;
    if (seen !== 1'b0) begin nerr++; $display("FAIL midrun_discard: out_valid seen=%b, required 0", seen); end
    issue(0, 8'h01, 8'h02, 1'b0, 1'b0, lat);
    nvec++;
    if ({lat == 8, cout[0], sum[0]} !== {1'b1, 9'h003}) begin
      nerr++; $display("FAIL midrun_fresh: lat=%0d cout,sum=%h, required 8 003", lat, {cout[0], sum[0]});
    end
    pop(0);
  endtask

  task automatic test_bpc4();
    int lat;
    issue(1, 8'h9C, 8'h87, 1'b1, 1'b0, lat);
    nvec++;
    if (lat !== 2) begin nerr++; $display("FAIL bpc4_latency: %0d, required 2", lat); end
    nvec++;
    if ({cout[1], sum[1]} !== 9'h124) begin
      nerr++; $display("FAIL bpc4_result: cout,sum=%h, required 124", {cout[1], sum[1]});
    end
    pop(1);
    nvec++;
    if ({ov[1], ir[1]} !== 2'b01) begin nerr++; $display("FAIL bpc4_release: ov,ir=%b, required 01", {ov[1], ir[1]}); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    issue(0, 8'h05, 8'h07, 1'b1, 1'b1, lat);
    nvec++;
    if ({cout[0], sum[0]} !== 9'h0FE) begin
      nerr++; $display("FAIL sub_borrow: cout,sum=%h, required 0FE", {cout[0], sum[0]});
    end
    pop(0);
    issue(0, 8'h07, 8'h05, 1'b0, 1'b1, lat);
    nvec++;
    if ({cout[0], sum[0]} !== 9'h102) begin
      nerr++; $display("FAIL sub_noborrow: cout,sum=%h, required 102", {cout[0], sum[0]});
    end
    pop(0);
  endtask
`endif

  // full=1: always valid/ready, checks accept spacing; full=0: random valid and backpressure.
  task automatic test_traffic(input int d, input bit full, input int ncyc);
    logic [8:0] q[$];
    logic [8:0] e;
    int last = -1;
    for (int cyc = 0; cyc < ncyc + steps[d] + 4; cyc++) begin
      @(negedge clk);
      a[d] = 8'($urandom); b[d] = 8'($urandom); cin[d] = 1'($urandom); sub[d] = rnd_sub();
      iv[d]   = (cyc < ncyc) && (full || ($urandom_range(3) != 0));
      ordy[d] = full || (cyc >= ncyc) || 1'($urandom);
      if (ov[d] && ordy[d]) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++; $display("FAIL traffic%0d_extra: cout,sum=%h, required no result", d, {cout[d], sum[d]});
        end else begin
          e = q.pop_front();
          if ({cout[d], sum[d]} !== e) begin
            nerr++; $display("FAIL traffic%0d_result: cout,sum=%h, required %h", d, {cout[d], sum[d]}, e);
          end
        end
      end
      if (iv[d] && ir[d]) begin
        if (full && last >= 0) begin
          nvec++;
          if (cyc - last !== steps[d] + 2) begin
            nerr++; $display("FAIL traffic%0d_spacing: %0d cycles, required %0d", d, cyc - last, steps[d] + 2);
          end
        end
        last = cyc;
        q.push_back(model(a[d], b[d], cin[d], sub[d]));
      end
    end
    iv[d] = 1'b0; ordy[d] = 1'b0;
    nvec++;
    if (q.size() !== 0) begin nerr++; $display("FAIL traffic%0d_drain: %0d pending, required 0", d, q.size()); end
  endtask

  initial begin
    test_reset();
    test_add_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_bpc4();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_traffic(0, 1'b1, 60);
    test_traffic(1, 1'b1, 30);
    test_traffic(0, 1'b0, 400);
    test_traffic(1, 1'b0, 200);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
